// File: rtl/bank_write_arbiter_pkg.sv
// Shared definitions for the bank write arbiter: state encoding,
// requester indices and the bank depth derivation.
package bank_write_arbiter_pkg;

    typedef enum logic {
        ST_INIT = 1'b0,
        ST_IDLE = 1'b1
    } state_t;

    localparam logic REQ_A = 1'b0;
    localparam logic REQ_B = 1'b1;

    // Number of registers in a bank addressed by 'bits' address bits.
    function automatic int unsigned nreg(input int unsigned bits);
        return 32'd1 << bits;
    endfunction

endpackage

// File: rtl/bank_write_arbiter_rr_arbiter2.sv
// Two-input round-robin arbiter. Grants are combinational; rrLast remembers
// the last winner so that contention goes to the other requester.
module rr_arbiter2
    import bank_write_arbiter_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       reqA,
    input  logic       reqB,
    input  logic       enable,
    output logic [1:0] gnt
);

    logic rrLast;

    // Pick at most one winner; on contention the one not granted last wins.
    always_comb begin
        gnt = 2'b00;
        if (enable) begin
            if (reqA && reqB) begin
                if (rrLast == REQ_A) begin
                    gnt[REQ_B] = 1'b1;
                end else begin
                    gnt[REQ_A] = 1'b1;
                end
            end else if (reqA) begin
                gnt[REQ_A] = 1'b1;
            end else if (reqB) begin
                gnt[REQ_B] = 1'b1;
            end
        end
    end

    // Track the last winner; reset to B so that A wins the first contention.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rrLast <= REQ_B;
        end else if (gnt[REQ_A]) begin
            rrLast <= REQ_A;
        end else if (gnt[REQ_B]) begin
            rrLast <= REQ_B;
        end
    end

endmodule

// File: rtl/bank_write_arbiter.sv
// Write-port sequencer for the register bank. Optionally sweeps every address
// to INIT_VAL after reset (macro BANK_INIT_EN), then shares the single write
// port between requesters A and B with round-robin arbitration. All bank
// write signals are registered.
module bank_write_arbiter
    import bank_write_arbiter_pkg::*;
#(
    parameter int unsigned           BIT_ADDR = 8,
    parameter int unsigned           BIT_DATO = 4,
    parameter logic [BIT_DATO-1:0]   INIT_VAL = '0
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                reqA,
    input  logic [BIT_ADDR-1:0] addrA,
    input  logic [BIT_DATO-1:0] datA,
    output logic                gntA,
    input  logic                reqB,
    input  logic [BIT_ADDR-1:0] addrB,
    input  logic [BIT_DATO-1:0] datB,
    output logic                gntB,
    output logic [BIT_ADDR-1:0] wr_addr,
    output logic [BIT_DATO-1:0] wr_dat,
    output logic                wr_en,
    output logic                busy
);

    logic [1:0] gnt;
    logic       arbEn;

    rr_arbiter2 u_arb (
        .clk    (clk),
        .rst    (rst),
        .reqA   (reqA),
        .reqB   (reqB),
        .enable (arbEn),
        .gnt    (gnt)
    );

    assign gntA = gnt[REQ_A];
    assign gntB = gnt[REQ_B];

`ifdef BANK_INIT_EN
    localparam int unsigned NREG  = nreg(BIT_ADDR);
    // One extra bit so the terminal count never aliases address 0.
    localparam int unsigned CNT_W = BIT_ADDR + 1;

    state_t           state;
    logic [CNT_W-1:0] cnt;

    // Requests are only seen once the sweep has finished.
    assign arbEn = (state == ST_IDLE);

    // FSM: sweep every address once, then forward the granted request.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= ST_INIT;
            cnt     <= '0;
            busy    <= 1'b1;
            wr_en   <= 1'b0;
            wr_addr <= '0;
            wr_dat  <= '0;
        end else begin
            case (state)
                ST_INIT: begin
                    wr_en   <= 1'b1;
                    wr_addr <= cnt[BIT_ADDR-1:0];
                    wr_dat  <= INIT_VAL;
                    cnt     <= cnt + 1'b1;
                    if (cnt == CNT_W'(NREG - 1)) begin
                        state <= ST_IDLE;
                        busy  <= 1'b0;
                    end
                end
                default: begin
                    if (gnt[REQ_A]) begin
                        wr_en   <= 1'b1;
                        wr_addr <= addrA;
                        wr_dat  <= datA;
                    end else if (gnt[REQ_B]) begin
                        wr_en   <= 1'b1;
                        wr_addr <= addrB;
                        wr_dat  <= datB;
                    end else begin
                        wr_en   <= 1'b0;
                    end
                end
            endcase
        end
    end
`else
    // No sweep: the arbiter is live straight out of reset.
    assign arbEn = 1'b1;
    assign busy  = 1'b0;

    // Register the winner's address/data; hold them when nothing is granted.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_en   <= 1'b0;
            wr_addr <= '0;
            wr_dat  <= '0;
        end else if (gnt[REQ_A]) begin
            wr_en   <= 1'b1;
            wr_addr <= addrA;
            wr_dat  <= datA;
        end else if (gnt[REQ_B]) begin
            wr_en   <= 1'b1;
            wr_addr <= addrB;
            wr_dat  <= datB;
        end else begin
            wr_en   <= 1'b0;
        end
    end
`endif

endmodule

// File: tb/tb_bank_write_arbiter.sv
// Self-checking bench for bank_write_arbiter (BIT_ADDR=3, BIT_DATO=4,
// INIT_VAL=4'hA). Covers both builds of BANK_INIT_EN.
module tb_bank_write_arbiter;

    localparam int unsigned BA = 3;
    localparam int unsigned BD = 4;
    localparam logic [BD-1:0] IV = 4'hA;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          reqA = 1'b0, reqB = 1'b0;
    logic [BA-1:0] addrA = '0, addrB = '0;
    logic [BD-1:0] datA = '0, datB = '0;
    logic          gntA, gntB, wr_en, busy;
    logic [BA-1:0] wr_addr;
    logic [BD-1:0] wr_dat;

    bank_write_arbiter #(.BIT_ADDR(BA), .BIT_DATO(BD), .INIT_VAL(IV)) dut (
        .clk     (clk),
        .rst     (rst),
        .reqA    (reqA),
        .addrA   (addrA),
        .datA    (datA),
        .gntA    (gntA),
        .reqB    (reqB),
        .addrB   (addrB),
        .datB    (datB),
        .gntB    (gntB),
        .wr_addr (wr_addr),
        .wr_dat  (wr_dat),
        .wr_en   (wr_en),
        .busy    (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [BA-1:0] addr;
        logic [BD-1:0] dat;
    } wr_t;

    typedef struct {
        logic          rA;
        logic          rB;
        logic [BA-1:0] aA;
        logic [BD-1:0] dA;
        logic [BA-1:0] aB;
        logic [BD-1:0] dB;
        logic          eA;
        logic          eB;
    } vec_t;

    wr_t  expQ[$];
    vec_t vecs[12];
    logic [BD-1:0] bankObs[8];

    int nChecks = 0;
    int nFails  = 0;

`ifdef BANK_INIT_EN
    localparam logic BUSY_RST = 1'b1;
`else
    localparam logic BUSY_RST = 1'b0;
`endif

    // Mirror of the bank, built only from the observed write stream.
    always @(posedge clk) begin
        if (!rst && wr_en) bankObs[wr_addr] <= wr_dat;
    end

    task automatic chk(input string name, input int unsigned act, input int unsigned exp);
        nChecks++;
        if (act !== exp) begin
            nFails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // After an edge: a queued write must appear now, otherwise wr_en must be low.
    task automatic checkOut(input string name);
        wr_t w;
        @(posedge clk);
        #1;
        if (expQ.size() > 0) begin
            w = expQ.pop_front();
            chk({name, " wr_en"}, 32'(wr_en), 1);
            chk({name, " wr_addr"}, 32'(wr_addr), 32'(w.addr));
            chk({name, " wr_dat"}, 32'(wr_dat), 32'(w.dat));
        end else begin
            chk({name, " wr_en idle"}, 32'(wr_en), 0);
        end
    endtask

    // Drive one cycle of requests, check grants, then the registered write.
    task automatic step(input string name, input vec_t v);
        wr_t w;
        @(negedge clk);
        reqA = v.rA; addrA = v.aA; datA = v.dA;
        reqB = v.rB; addrB = v.aB; datB = v.dB;
        #1;
        chk({name, " gntA"}, 32'(gntA), 32'(v.eA));
        chk({name, " gntB"}, 32'(gntB), 32'(v.eB));
        if (v.eA) begin
            w.addr = v.aA; w.dat = v.dA; expQ.push_back(w);
        end else if (v.eB) begin
            w.addr = v.aB; w.dat = v.dB; expQ.push_back(w);
        end
        checkOut(name);
    endtask

    task automatic mk(input int i, input logic rA, input logic [BA-1:0] aA,
                      input logic [BD-1:0] dA, input logic rB, input logic [BA-1:0] aB,
                      input logic [BD-1:0] dB, input logic eA, input logic eB);
        vecs[i].rA = rA; vecs[i].aA = aA; vecs[i].dA = dA;
        vecs[i].rB = rB; vecs[i].aB = aB; vecs[i].dB = dB;
        vecs[i].eA = eA; vecs[i].eB = eB;
    endtask

    // Reset, release on a falling edge, and let any sweep finish unchecked.
    task automatic resetAndSettle();
        bit done;
        reqA = 1'b0; reqB = 1'b0;
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        done = 1'b0;
        for (int i = 0; i < 20 && !done; i++) begin
            if (!busy) done = 1'b1;
            else begin
                @(posedge clk);
                #1;
            end
        end
        chk("settle busy low", 32'(busy), 0);
        expQ.delete();
    endtask

    initial begin
        vec_t v;
        bit   found;

        // Reset values while reset is held.
        #2;
        chk("rst wr_en", 32'(wr_en), 0);
        chk("rst wr_addr", 32'(wr_addr), 0);
        chk("rst wr_dat", 32'(wr_dat), 0);
        chk("rst busy", 32'(busy), 32'(BUSY_RST));

`ifdef BANK_INIT_EN
        // Sweep with reqA held: A must wait until busy falls.
        @(negedge clk);
        reqA = 1'b1; addrA = 3'd3; datA = 4'd5;
        rst = 1'b0;
        for (int i = 0; i < 8; i++) begin
            wr_t w;
            #1;
            chk("sweep busy", 32'(busy), 1);
            chk("sweep gntA", 32'(gntA), 0);
            w.addr = BA'(i); w.dat = IV; expQ.push_back(w);
            checkOut("sweep");
            @(negedge clk);
        end
        v = '{1'b1, 1'b0, 3'd3, 4'd5, 3'd0, 4'd0, 1'b1, 1'b0};
        chk("post-sweep busy", 32'(busy), 0);
        step("first idle grant", v);
        v = '{1'b0, 1'b0, 3'd3, 4'd5, 3'd0, 4'd0, 1'b0, 1'b0};
        step("after grant", v);

        // Reset in the middle of the sweep.
        reqA = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            @(posedge clk);
            #1;
            if (wr_en && wr_addr == 3'd4) found = 1'b1;
        end
        chk("reached sweep addr 4", 32'(found), 1);
        rst = 1'b1;
        #1;
        chk("mid rst wr_en", 32'(wr_en), 0);
        chk("mid rst wr_addr", 32'(wr_addr), 0);
        chk("mid rst wr_dat", 32'(wr_dat), 0);
        chk("mid rst busy", 32'(busy), 1);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        chk("restart wr_en", 32'(wr_en), 1);
        chk("restart wr_addr", 32'(wr_addr), 0);
        chk("restart wr_dat", 32'(wr_dat), 32'(IV));
`else
        // No sweep: B is granted in the very first cycle after release.
        @(negedge clk);
        reqB = 1'b1; addrB = 3'd2; datB = 4'd7;
        rst = 1'b0;
        v = '{1'b0, 1'b1, 3'd0, 4'd0, 3'd2, 4'd7, 1'b0, 1'b1};
        #1;
        chk("noinit busy", 32'(busy), 0);
        step("noinit first gntB", v);
`endif

        // Both held from reset state: A,B,A,B with wr_en every cycle.
        resetAndSettle();
        v = '{1'b1, 1'b1, 3'd1, 4'd1, 3'd2, 4'd2, 1'b1, 1'b0};
        step("b2b 1", v);
        v = '{1'b1, 1'b1, 3'd3, 4'd3, 3'd4, 4'd4, 1'b0, 1'b1};
        step("b2b 2", v);
        v = '{1'b1, 1'b1, 3'd5, 4'd5, 3'd6, 4'd6, 1'b1, 1'b0};
        step("b2b 3", v);
        v = '{1'b1, 1'b1, 3'd7, 4'd7, 3'd0, 4'd8, 1'b0, 1'b1};
        step("b2b 4", v);

        // Table; rrLast=B at the start.
        resetAndSettle();
        mk(0,  1, 3'd3, 4'd5,  0, 3'd0, 4'd0,  1, 0);
        mk(1,  0, 3'd0, 4'd0,  0, 3'd0, 4'd0,  0, 0);
        mk(2,  1, 3'd1, 4'd1,  1, 3'd2, 4'd2,  0, 1);
        mk(3,  1, 3'd4, 4'd3,  1, 3'd5, 4'd4,  1, 0);
        mk(4,  1, 3'd6, 4'd1,  1, 3'd6, 4'd2,  0, 1);
        mk(5,  1, 3'd6, 4'd1,  1, 3'd6, 4'd2,  1, 0);
        mk(6,  0, 3'd0, 4'd0,  1, 3'd7, 4'd9,  0, 1);
        mk(7,  0, 3'd0, 4'd0,  1, 3'd0, 4'd15, 0, 1);
        mk(8,  1, 3'd1, 4'd6,  1, 3'd2, 4'd7,  1, 0);
        mk(9,  0, 3'd0, 4'd0,  0, 3'd0, 4'd0,  0, 0);
        mk(10, 1, 3'd5, 4'd5,  0, 3'd0, 4'd0,  1, 0);
        mk(11, 1, 3'd3, 4'd3,  1, 3'd4, 4'd4,  0, 1);
        for (int i = 0; i < 12; i++) begin
            step($sformatf("vec %0d", i), vecs[i]);
            if (i == 6) chk("same-addr bank[6]", 32'(bankObs[6]), 1);
        end
        v = '{1'b0, 1'b0, 3'd0, 4'd0, 3'd0, 4'd0, 1'b0, 1'b0};
        step("drain", v);
        chk("scoreboard empty", 32'(expQ.size()), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end

    // Global watchdog.
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "timeout");
    end

endmodule
